// File: rtl/clock_monitor.sv
`timescale 1ns/1ps
// Measures the half-period of an asynchronous slow clock in clk_in cycles,
// flags out-of-tolerance intervals and detects loss of the monitored clock.
module clock_monitor #(
  parameter int HALF_NOM   = 5,
  parameter int TOL        = 1,
  parameter int LOSS_LIMIT = 32
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       mon_clk,
  input  logic       enable,
  input  logic       err_clr,
  output logic       rise,
  output logic       fall,
  output logic [7:0] half_period,
  output logic       period_valid,
  output logic       freq_err,
  output logic       clk_lost
);

  typedef enum logic [1:0] {IDLE, ACQ, TRACK, LOST} state_t;

  localparam logic [7:0] LOSS_CNT = 8'(LOSS_LIMIT - 1);
  localparam logic [8:0] NOM_9    = 9'(HALF_NOM);
  localparam logic [8:0] TOL_9    = 9'(TOL);
  localparam logic [8:0] HI_9     = 9'(HALF_NOM + TOL);

  state_t     state, state_nxt;
  logic       sync1, sync2, hist;
  logic [7:0] cnt;
  logic [8:0] meas;
  logic       edge_ev, loss, capture, out_of_tol;

  assign edge_ev = sync2 ^ hist;
  assign loss    = (cnt >= LOSS_CNT) && !edge_ev;
  assign meas    = {1'b0, cnt} + 9'd1;
  // Low bound is tested as meas + TOL < HALF_NOM so a small HALF_NOM cannot wrap.
  assign out_of_tol = ((meas + TOL_9) < NOM_9) || (meas > HI_9);

  // NOTE: every sequential process uses non-blocking assignments so all flops
  // sample pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
      state <= IDLE;
    end else begin
      sync1 <= mon_clk;
      sync2 <= sync1;
      hist  <= sync2;
      state <= state_nxt;
    end
  end

  // NOTE: defaults are assigned before the case so no path leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  state_nxt = ACQ;
        ACQ: begin
          if (edge_ev)   state_nxt = TRACK;
          else if (loss) state_nxt = LOST;
        end
        TRACK: begin
          if (edge_ev)   capture   = 1'b1;
          else if (loss) state_nxt = LOST;
        end
        LOST: begin
          if (edge_ev) state_nxt = TRACK;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      rise         <= 1'b0;
      fall         <= 1'b0;
      half_period  <= '0;
      period_valid <= 1'b0;
      freq_err     <= 1'b0;
      clk_lost     <= 1'b0;
    end else begin
      rise <= sync2 & ~hist;
      fall <= ~sync2 & hist;

      if (state == IDLE || edge_ev) cnt <= '0;
      else if (cnt != 8'hff)        cnt <= cnt + 8'd1;

      if (!enable) begin
        period_valid <= 1'b0;
        clk_lost     <= 1'b0;
      end else if (capture) begin
        half_period  <= meas[7:0];
        period_valid <= 1'b1;
      end else if (state != LOST && state_nxt == LOST) begin
        period_valid <= 1'b0;
        clk_lost     <= 1'b1;
      end else if (state == LOST && edge_ev) begin
        clk_lost     <= 1'b0;
      end

      // A fresh error outranks a simultaneous clear.
      if (capture && out_of_tol) freq_err <= 1'b1;
      else if (err_clr)          freq_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clock_monitor.sv
`timescale 1ns/1ps
// Scoreboard bench for clock_monitor: stimulus pushes the expected post-strobe
// output state for every mon_clk edge; a monitor pops it on each rise/fall strobe.
module tb_clock_monitor;

  localparam int HALF_NOM   = 5;
  localparam int TOL        = 1;
  localparam int LOSS_LIMIT = 32;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       mon_clk = 1'b0;
  logic       enable = 1'b0;
  logic       err_clr = 1'b0;
  logic       rise, fall, period_valid, freq_err, clk_lost;
  logic [7:0] half_period;

  clock_monitor #(.HALF_NOM(HALF_NOM), .TOL(TOL), .LOSS_LIMIT(LOSS_LIMIT)) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .mon_clk      (mon_clk),
    .enable       (enable),
    .err_clr      (err_clr),
    .rise         (rise),
    .fall         (fall),
    .half_period  (half_period),
    .period_valid (period_valid),
    .freq_err     (freq_err),
    .clk_lost     (clk_lost)
  );

  always #10 clk_in = ~clk_in;

  typedef enum {M_IDLE, M_ACQ, M_TRACK} mode_t;
  typedef struct {
    bit         is_rise;
    logic [7:0] hp;
    bit         valid;
    bit         err;
    bit         lost;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         last_cyc = 0;
  mode_t      m_mode   = M_IDLE;
  logic [7:0] m_hp     = 8'd0;
  bit         m_valid  = 1'b0;
  bit         m_err    = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe consumes exactly one expectation.
  always @(negedge clk_in) begin : monitor
    exp_t e;
    if (reset === 1'b1 && (rise === 1'b1 || fall === 1'b1)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'(rise | fall), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rise", 32'(rise), 32'(e.is_rise));
        check("fall", 32'(fall), 32'(!e.is_rise));
        check("half_period", 32'(half_period), 32'(e.hp));
        check("period_valid", 32'(period_valid), 32'(e.valid));
        check("freq_err", 32'(freq_err), 32'(e.err));
        check("clk_lost", 32'(clk_lost), 32'(e.lost));
      end
    end
  end

  // Wait 'gap' cycles, toggle mon_clk and predict the outputs seen at its strobe.
  // clr_mid pulses err_clr well clear of any capture; coincide pulses it on the
  // very cycle this edge's capture is registered.
  task automatic do_edge(input int gap, input bit clr_mid, input bit coincide);
    exp_t e;
    int   g;
    int   k;
    bit   do_mid;
    bit   set;
    do_mid = clr_mid && (gap >= 5);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk_in);
      err_clr = do_mid && (i == 2);
      if (do_mid && i == 2) m_err = 1'b0;
      if (do_mid && i == 3) check("err_clr_mid", 32'(freq_err), 32'd0);
      if (m_mode == M_TRACK) begin
        k = cyc - last_cyc;
        if (k == LOSS_LIMIT + 2) check("lost_early", 32'(clk_lost), 32'd0);
        if (k == LOSS_LIMIT + 3) begin
          check("lost_set", 32'(clk_lost), 32'd1);
          check("lost_valid", 32'(period_valid), 32'd0);
        end
      end
    end
    err_clr = 1'b0;
    mon_clk = ~mon_clk;
    g = cyc - last_cyc;
    last_cyc = cyc;
    set = 1'b0;
    case (m_mode)
      M_ACQ:   m_mode = M_TRACK;
      M_TRACK: begin
        if (g <= LOSS_LIMIT) begin
          m_hp    = 8'(g);
          m_valid = 1'b1;
          set     = (g < HALF_NOM - TOL) || (g > HALF_NOM + TOL);
        end else begin
          m_valid = 1'b0;
        end
      end
      default: ;
    endcase
    m_err = set | (coincide ? 1'b0 : m_err);
    e.is_rise = mon_clk;
    e.hp      = m_hp;
    e.valid   = m_valid;
    e.err     = m_err;
    e.lost    = 1'b0;
    exp_q.push_back(e);
    if (coincide) begin
      @(negedge clk_in);
      @(negedge clk_in);
      err_clr = 1'b1;
      @(negedge clk_in);
      err_clr = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_in);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    #5 reset = 1'b0;
    idle_cycles(3);
    check("rst_rise", 32'(rise), 32'd0);
    check("rst_fall", 32'(fall), 32'd0);
    check("rst_half_period", 32'(half_period), 32'd0);
    check("rst_valid", 32'(period_valid), 32'd0);
    check("rst_err", 32'(freq_err), 32'd0);
    check("rst_lost", 32'(clk_lost), 32'd0);

    // Nominal 5-cycle toggling, then random in-tolerance gaps.
    reset    = 1'b1;
    enable   = 1'b1;
    m_mode   = M_ACQ;
    last_cyc = cyc;
    do_edge(3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) do_edge(5, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      do_edge(int'($urandom_range(HALF_NOM - TOL, HALF_NOM + TOL)), 1'($urandom_range(0, 1)), 1'b0);

    // Slow clock: sticky error, mid-gap clear, clear coinciding with a capture.
    for (int i = 0; i < 3; i++) do_edge(7, 1'b0, 1'b0);
    do_edge(7, 1'b1, 1'b0);
    do_edge(7, 1'b0, 1'b1);
    do_edge(5, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++)
      do_edge(int'($urandom_range(2, 9)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));

    // Loss, recovery, and gaps around the loss threshold (edge wins the tie).
    do_edge(5, 1'b0, 1'b0);
    do_edge(LOSS_LIMIT + 10, 1'b0, 1'b0);
    do_edge(5, 1'b0, 1'b0);
    do_edge(LOSS_LIMIT, 1'b0, 1'b0);
    do_edge(LOSS_LIMIT + 1, 1'b0, 1'b0);
    do_edge(5, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      do_edge(int'($urandom_range(LOSS_LIMIT - 2, LOSS_LIMIT + 4)), 1'b0, 1'b0);
      do_edge(int'($urandom_range(4, 6)), 1'b0, 1'b0);
    end

    // Drop enable in TRACK; strobes continue while disabled.
    do_edge(7, 1'b0, 1'b0);
    idle_cycles(4);
    enable  = 1'b0;
    m_mode  = M_IDLE;
    m_valid = 1'b0;
    @(negedge clk_in);
    check("dis_valid", 32'(period_valid), 32'd0);
    check("dis_half_period", 32'(half_period), 32'(m_hp));
    check("dis_err", 32'(freq_err), 32'(m_err));
    check("dis_lost", 32'(clk_lost), 32'd0);
    do_edge(6, 1'b0, 1'b0);
    do_edge(9, 1'b0, 1'b0);
    do_edge(LOSS_LIMIT + 5, 1'b0, 1'b0);
    idle_cycles(4);
    enable = 1'b1;
    m_mode = M_ACQ;
    do_edge(3, 1'b0, 1'b0);
    do_edge(5, 1'b0, 1'b0);
    do_edge(7, 1'b0, 1'b0);

    // Asynchronous reset mid-TRACK discards state; first edge after is partial.
    if (mon_clk) do_edge(5, 1'b0, 1'b0);
    idle_cycles(4);
    #3 reset = 1'b0;
    #2;
    check("arst_rise", 32'(rise), 32'd0);
    check("arst_fall", 32'(fall), 32'd0);
    check("arst_half_period", 32'(half_period), 32'd0);
    check("arst_valid", 32'(period_valid), 32'd0);
    check("arst_err", 32'(freq_err), 32'd0);
    check("arst_lost", 32'(clk_lost), 32'd0);
    m_mode  = M_ACQ;
    m_hp    = 8'd0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    idle_cycles(3);
    reset    = 1'b1;
    last_cyc = cyc;
    do_edge(3, 1'b0, 1'b0);
    do_edge(5, 1'b0, 1'b0);
    do_edge(4, 1'b0, 1'b0);

    idle_cycles(6);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_monitor.md
CLOCK_MONITOR -- requirements
Module: clock_monitor

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; the ports are clk_in and reset.
REQ-002 Parameter HALF_NOM, default 5, SHALL be the nominal half-period of mon_clk in clk_in cycles.
REQ-003 Parameter TOL, default 1, SHALL be the allowed deviation from HALF_NOM in clk_in cycles.
REQ-004 Parameter LOSS_LIMIT, default 32, SHALL be the clk_in cycles without a mon_clk edge that declare loss; legal range 2..255.
REQ-005 Ports (name, direction, width, meaning):
- clk_in: in, 1, system clock (50 MHz).
- reset: in, 1, asynchronous, active-low.
- mon_clk: in, 1, monitored slow clock, asynchronous to clk_in.
- enable: in, 1, enables measurement.
- err_clr: in, 1, single-cycle clear of freq_err.
- rise: out, 1, one-cycle strobe on a mon_clk rising edge.
- fall: out, 1, one-cycle strobe on a mon_clk falling edge.
- half_period: out, 8, last measured half-period in clk_in cycles.
- period_valid: out, 1, half_period holds a valid measurement.
- freq_err: out, 1, sticky out-of-tolerance flag.
- clk_lost: out, 1, no mon_clk edge within LOSS_LIMIT cycles.

Function
REQ-006 mon_clk SHALL pass through a 2-flop synchronizer, then a third history flop; an edge event is a difference between the 2nd and 3rd flops.
REQ-007 rise and fall SHALL be registered and high for exactly one cycle, 3 clk_in edges after the first edge that samples the new mon_clk level.
REQ-008 rise and fall SHALL be generated regardless of enable or state.
REQ-009 An 8-bit counter cnt SHALL clear to 0 on every edge event, increment otherwise, and saturate at 255.
REQ-010 The state machine SHALL have states IDLE, ACQ, TRACK and LOST.
REQ-011 IDLE: cnt is held at 0. The FSM goes to ACQ on the cycle after enable=1.
REQ-012 ACQ: the first edge event goes to TRACK and captures no measurement, because the first interval is partial.
REQ-013 ACQ or TRACK: when cnt reaches LOSS_LIMIT-1 without an edge, the FSM goes to LOST. clk_lost goes to 1 and period_valid goes to 0 on the same registered update.
REQ-014 TRACK: on each edge event, half_period SHALL load cnt+1 and period_valid SHALL go to 1. For a 5 MHz mon_clk on a 50 MHz clk_in, the captured value is 5.
REQ-015 TRACK: on each capture, freq_err SHALL set if cnt+1 < HALF_NOM-TOL or cnt+1 > HALF_NOM+TOL. The comparison uses 9-bit unsigned arithmetic so it does not underflow.
REQ-016 LOST: the next edge event SHALL go to TRACK and clear clk_lost, capturing no measurement. period_valid stays 0 until the following edge.
REQ-017 enable=0 in any state SHALL force IDLE on the next cycle and clear period_valid and clk_lost. half_period and freq_err hold their values.
REQ-018 freq_err SHALL clear only on err_clr=1 or reset. If err_clr and a new error occur in the same cycle, the set wins.
REQ-019 An edge event in the same cycle as the loss threshold SHALL win: the FSM stays in TRACK and captures the measurement.

Reset
REQ-020 While reset=0, all flops SHALL clear immediately: synchronizer and history flops, cnt, state=IDLE, rise, fall, half_period=0, period_valid, freq_err and clk_lost.
REQ-021 Reset asserted mid-measurement SHALL discard the partial count. After release, the block returns to ACQ, which requires a fresh first edge.

Verification
REQ-022 Release reset, enable=1, mon_clk toggles every 5 cycles -> after the second edge: half_period=5, period_valid=1, freq_err=0, clk_lost=0.
REQ-023 mon_clk toggles every 7 cycles -> freq_err=1 at the first capture and stays 1. One err_clr pulse during a steady 7-cycle toggle -> freq_err re-sets at the next capture. err_clr on the same cycle as an error capture -> freq_err stays 1.
REQ-024 In TRACK, mon_clk held low -> clk_lost=1 and period_valid=0, 32 cycles after the last edge event. Toggling resumes -> clk_lost=0 at the first edge; half_period=5 and period_valid=1 at the second edge.
REQ-025 A single mon_clk rising edge -> rise is high for exactly 1 cycle, 3 clk_in edges after sampling, and fall stays 0. The same holds with enable=0.
REQ-026 Assert reset mid-TRACK -> all outputs are 0 asynchronously. After release, the first edge produces no capture and period_valid=0.
REQ-027 Drop enable in TRACK -> IDLE next cycle, period_valid=0, half_period and freq_err retained.
